round_pack_float_param: RTL

ROUND_PACK_FLOAT_PARAM -- requirements
Module: round_pack_float_param

---
 rtl/round_pack_float_param_if.sv | 40 ++++
 rtl/round_pack_float_param.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/round_pack_float_param_if.sv
// Block-level handshake and data bus for round_pack_float_param.
// round_mode exists only when ROUNDPACK_RMODE_EN is defined.
interface round_pack_float_param_if #(
    parameter int EXP_W  = 11,
    parameter int FRAC_W = 52,
    parameter int SIG_W  = 64
);
    logic                     ap_start;
    logic                     ap_done;
    logic                     ap_idle;
    logic                     ap_ready;
    logic                     zSign;
    logic signed [EXP_W+1:0]  zExp;
    logic [SIG_W-1:0]         zSig;
    logic [31:0]              float_exception_flag_i;
    logic [31:0]              float_exception_flag_o;
    logic                     float_exception_flag_o_ap_vld;
    logic [EXP_W+FRAC_W:0]    ap_return;
`ifdef ROUNDPACK_RMODE_EN
    logic [1:0]               round_mode;
`endif

    modport master (
`ifdef ROUNDPACK_RMODE_EN
        output round_mode,
`endif
        output ap_start, zSign, zExp, zSig, float_exception_flag_i,
        input  ap_done, ap_idle, ap_ready, float_exception_flag_o,
        input  float_exception_flag_o_ap_vld, ap_return
    );

    modport slave (
`ifdef ROUNDPACK_RMODE_EN
        input  round_mode,
`endif
        input  ap_start, zSign, zExp, zSig, float_exception_flag_i,
        output ap_done, ap_idle, ap_ready, float_exception_flag_o,
        output float_exception_flag_o_ap_vld, ap_return
    );
endinterface

// File: rtl/round_pack_float_param.sv
// Round an extended significand and pack {sign, exponent, fraction}; 4-state one-hot FSM.
// Define ROUNDPACK_RMODE_EN to add the runtime round_mode input (otherwise nearest-even).
module round_pack_float_param #(
    parameter int EXP_W  = 11,
    parameter int FRAC_W = 52,
    parameter int SIG_W  = 64
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    round_pack_float_param_if.slave bus
);
    localparam int RB = SIG_W - FRAC_W - 2;
    localparam int SW = FRAC_W + 2;
    localparam int RW = 1 + EXP_W + FRAC_W;
    localparam logic [EXP_W+1:0] MAXE = {2'b00, {EXP_W{1'b1}}} - (EXP_W+2)'(2);

    localparam logic [3:0] S_IDLE  = 4'b0001;
    localparam logic [3:0] S_SHIFT = 4'b0010;
    localparam logic [3:0] S_ROUND = 4'b0100;
    localparam logic [3:0] S_PACK  = 4'b1000;

    logic [3:0]       state_q, state_d;
    logic             sign_q, sign_d;
    logic [EXP_W+1:0] exp_q, exp_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic [1:0]       mode_q, mode_d;
    logic [31:0]      flags_q, flags_d;
    logic [RW-1:0]    ret_q, ret_d;

    logic [1:0]       mode_in;
`ifdef ROUNDPACK_RMODE_EN
    assign mode_in = bus.round_mode;
`else
    assign mode_in = 2'd0;
`endif

    function automatic logic [SIG_W-1:0] inc_f(input logic [1:0] m, input logic sg);
        logic [SIG_W-1:0] half, ones;
        half = '0;
        half[RB-1] = 1'b1;
        ones = '0;
        ones[RB-1:0] = '1;
        case (m)
            2'd0:    inc_f = half;
            2'd1:    inc_f = '0;
            2'd2:    inc_f = sg ? ones : '0;
            default: inc_f = sg ? '0 : ones;
        endcase
    endfunction

    // Plain addition: a significand carry past the hidden bit bumps the exponent.
    function automatic logic [RW-1:0] pack_f(input logic sg, input logic [EXP_W-1:0] e,
                                             input logic [SW-1:0] s);
        pack_f = {sg, {(EXP_W+FRAC_W){1'b0}}} + {1'b0, e, {FRAC_W{1'b0}}} + RW'(s);
    endfunction

    logic [SIG_W-1:0] inc_in, inc_r, shift_mask, shift_sig;
    logic [EXP_W+1:0] shamt;
    logic             ovf_in;
    logic [RW-1:0]    ovf_ret, rnd_ret;
    logic [SW-1:0]    s_raw, s_rnd;
    logic [RB-1:0]    low_bits, half_low;
    logic [EXP_W-1:0] exp_rnd;

    always_comb begin
        inc_in  = inc_f(mode_in, bus.zSign);
        ovf_in  = ($signed(bus.zExp) > $signed(MAXE)) ||
                  ((bus.zExp == MAXE) && (((bus.zSig + inc_in) >> (SIG_W-1)) != '0));
        ovf_ret = (inc_in == '0) ? {bus.zSign, {(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}}
                                 : {bus.zSign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};

        shamt      = -exp_q;
        shift_mask = ~({SIG_W{1'b1}} << shamt);
        if (32'(shamt) >= 32'(SIG_W))
            shift_sig = SIG_W'(sig_q != '0);
        else
            shift_sig = (sig_q >> shamt) | SIG_W'((sig_q & shift_mask) != '0);

        inc_r    = inc_f(mode_q, sign_q);
        low_bits = sig_q[RB-1:0];
        half_low = '0;
        half_low[RB-1] = 1'b1;
        s_raw    = SW'((sig_q + inc_r) >> RB);
        s_rnd    = s_raw;
        if (mode_q == 2'd0 && low_bits == half_low)
            s_rnd[0] = 1'b0;
        exp_rnd  = (s_rnd == '0) ? '0 : exp_q[EXP_W-1:0];
        rnd_ret  = pack_f(sign_q, exp_rnd, s_rnd);
    end

    // ap_return loads on the way into PACK so it is valid in the same cycle as ap_done.
    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        sig_d   = sig_q;
        mode_d  = mode_q;
        flags_d = flags_q;
        ret_d   = ret_q;
        case (state_q)
            S_IDLE: begin
                if (bus.ap_start) begin
                    sign_d  = bus.zSign;
                    exp_d   = bus.zExp;
                    sig_d   = bus.zSig;
                    mode_d  = mode_in;
                    flags_d = '0;
                    if (ovf_in) begin
                        flags_d = 32'd9;
                        ret_d   = ovf_ret;
                        state_d = S_PACK;
                    end else if (bus.zExp[EXP_W+1]) begin
                        state_d = S_SHIFT;
                    end else begin
                        state_d = S_ROUND;
                    end
                end
            end
            S_SHIFT: begin
                sig_d = shift_sig;
                exp_d = '0;
                if (shift_sig[RB-1:0] != '0)
                    flags_d = flags_q | 32'd4;
                state_d = S_ROUND;
            end
            S_ROUND: begin
                if (low_bits != '0)
                    flags_d = flags_q | 32'd1;
                ret_d   = rnd_ret;
                state_d = S_PACK;
            end
            S_PACK:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= S_IDLE;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            sig_q   <= '0;
            mode_q  <= '0;
            flags_q <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            sig_q   <= sig_d;
            mode_q  <= mode_d;
            flags_q <= flags_d;
            ret_q   <= ret_d;
        end
    end

    assign bus.ap_done   = (state_q == S_PACK);
    assign bus.ap_ready  = (state_q == S_PACK);
    assign bus.ap_idle   = (state_q == S_IDLE) && !bus.ap_start;
    assign bus.ap_return = ret_q;
    assign bus.float_exception_flag_o = (state_q == S_PACK) ?
        (bus.float_exception_flag_i | flags_q) : bus.float_exception_flag_i;
    assign bus.float_exception_flag_o_ap_vld = (state_q == S_PACK) && (flags_q != '0);
endmodule
